// File: rtl/mac_send_pkg.sv
// Shared Ethernet II constants and state encodings for the transmit header framer
// (the same encodings are used by the receive-side header parser).
package mac_send_pkg;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam logic [47:0] ETH_BCAST    = 48'hFFFF_FFFF_FFFF;
    localparam logic [2:0]  MAC_HI_BYTE  = 3'd5;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DST_ADDR = 3'd1;
    localparam logic [2:0] ST_SRC_ADDR = 3'd2;
    localparam logic [2:0] ST_PROTO    = 3'd3;
    localparam logic [2:0] ST_PAYLOAD  = 3'd4;
    localparam logic [2:0] ST_PAD      = 3'd5;
    localparam logic [2:0] ST_GAP      = 3'd6;

    // Byte idx of a MAC address, idx 5 being the first byte on the wire.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        return mac[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mac_send.sv
// Ethernet II transmit framer: emits dst/src MAC and EtherType, passes the payload
// through with zero padding to the minimum size, then holds an inter-frame gap.
module mac_send
    import mac_send_pkg::*;
#(
    parameter int MIN_PAYLOAD = 46,
    parameter int IFG_CYCLES  = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [47:0] local_mac,
    input  logic        tx_request,
    input  logic        is_arp,
    input  logic        broadcast,
    input  logic [47:0] remote_mac,
    input  logic [7:0]  payload_data,
    input  logic        payload_valid,
    output logic        tx_ack,
    output logic        payload_rd,
    output logic        tx_enable,
    output logic [7:0]  tx_data,
    output logic        busy
);

    localparam logic [5:0] MIN_CNT  = 6'(MIN_PAYLOAD);
    localparam logic [3:0] GAP_LAST = 4'(IFG_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic [47:0] dst_q, dst_d;
    logic        arp_q, arp_d;
    logic        ack_q, ack_d;
    logic        en_q, en_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] type_s;

    assign type_s = arp_q ? ETH_TYPE_ARP : ETH_TYPE_IP;

    // Next-state and next-output-byte logic; outputs are registered one cycle later.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        dst_d   = dst_q;
        arp_d   = arp_q;
        ack_d   = 1'b0;
        en_d    = 1'b0;
        data_d  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (tx_request) begin
                    dst_d   = broadcast ? ETH_BCAST : remote_mac;
                    arp_d   = is_arp;
                    ack_d   = 1'b1;
                    en_d    = 1'b1;
                    data_d  = mac_byte(dst_d, MAC_HI_BYTE);
                    idx_d   = MAC_HI_BYTE - 3'd1;
                    cnt_d   = 6'd0;
                    state_d = ST_DST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DST_ADDR: begin
                en_d   = 1'b1;
                data_d = mac_byte(dst_q, idx_q);
                if (idx_q == 3'd0) begin
                    idx_d   = MAC_HI_BYTE;
                    state_d = ST_SRC_ADDR;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            ST_SRC_ADDR: begin
                en_d   = 1'b1;
                data_d = mac_byte(local_mac, idx_q);
                if (idx_q == 3'd0) begin
                    idx_d   = 3'd1;
                    state_d = ST_PROTO;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            ST_PROTO: begin
                en_d = 1'b1;
                if (idx_q == 3'd1) begin
                    data_d = type_s[15:8];
                    idx_d  = 3'd0;
                end else begin
                    data_d  = type_s[7:0];
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (payload_valid) begin
                    en_d   = 1'b1;
                    data_d = payload_data;
                    if (cnt_q < MIN_CNT) begin
                        cnt_d = cnt_q + 6'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (cnt_q < MIN_CNT) begin
                    // First pad byte goes out right away so tx_enable stays continuous.
                    en_d    = 1'b1;
                    cnt_d   = cnt_q + 6'd1;
                    gap_d   = 4'd0;
                    state_d = (cnt_q + 6'd1 == MIN_CNT) ? ST_GAP : ST_PAD;
                end else begin
                    // This cycle already shows tx_enable low next, so it counts toward the gap.
                    gap_d   = 4'd1;
                    state_d = ST_GAP;
                end
            end
            ST_PAD: begin
                en_d  = 1'b1;
                cnt_d = cnt_q + 6'd1;
                gap_d = 4'd0;
                if (cnt_q + 6'd1 == MIN_CNT) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 6'd0;
            gap_q   <= 4'd0;
            dst_q   <= 48'd0;
            arp_q   <= 1'b0;
            ack_q   <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            dst_q   <= dst_d;
            arp_q   <= arp_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

    assign payload_rd = (state_q == ST_PAYLOAD) && payload_valid && !reset;
    assign tx_ack     = ack_q;
    assign tx_enable  = en_q;
    assign tx_data    = data_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
